// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA frame size capture with optional key-colour bounding box (VGA_CAPTURE_BBOX_EN)
module vga_capture #(
  parameter logic [7:0] KEY_R = 8'hFF,
  parameter logic [7:0] KEY_G = 8'hFF,
  parameter logic [7:0] KEY_B = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vga_clk,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic       vga_blank_n,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  input  logic       chipselect,
  input  logic       read,
  input  logic [3:0] address,
  output logic [7:0] readdata,
  output logic       irq
);

  localparam logic [1:0] ST_SEEK   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic       clk_q, clk_d, hs_q, vs_q, blank_q;
  logic [7:0] r_q, g_q, b_q;
  logic [1:0] state;
  logic [9:0] x_cnt, y_cnt, line_width;
  logic       prev_blank;
  logic [9:0] res_width, res_height;
  logic [7:0] frame_count;
  logic       frame_valid;
  logic [9:0] snap_width, snap_height;
  logic [7:0] snap_frame_count;
  logic       status_hit;

  logic strobe, start_frame, publish, rd_en, rd_status;
  assign strobe      = clk_q & ~clk_d;
  assign start_frame = (state == ST_SYNC) && vs_q;
  assign publish     = (state == ST_ACTIVE) && !vs_q;
  assign rd_en       = chipselect && read;
  assign rd_status   = rd_en && (address == 4'd0);

  // Register generator outputs once; keep previous pixel clock for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_q   <= 1'b0;
      clk_d   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
    end else begin
      clk_q   <= vga_clk;
      clk_d   <= clk_q;
      hs_q    <= vga_hs;
      vs_q    <= vga_vs;
      blank_q <= vga_blank_n;
      r_q     <= vga_r;
      g_q     <= vga_g;
      b_q     <= vga_b;
    end
  end

  // Frame tracking: find a vsync, wait for its end, then measure until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SEEK;
    end else begin
      case (state)
        ST_SEEK:   if (!vs_q) state <= ST_SYNC;
        ST_SYNC:   if (vs_q) state <= ST_ACTIVE;
        ST_ACTIVE: if (!vs_q) state <= ST_SYNC;
        default:   state <= ST_SEEK;
      endcase
    end
  end

  // Pixel position and line geometry counters, advanced on each pixel strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt      <= 10'd0;
      y_cnt      <= 10'd0;
      line_width <= 10'd0;
      prev_blank <= 1'b0;
    end else begin
      if (strobe) prev_blank <= blank_q;
      if (start_frame) begin
        x_cnt      <= 10'd0;
        y_cnt      <= 10'd0;
        line_width <= 10'd0;
      end else if (strobe) begin
        if (blank_q) begin
          if (x_cnt != 10'h3FF) x_cnt <= x_cnt + 10'd1;
        end else begin
          x_cnt <= 10'd0;
          if (prev_blank) begin
            line_width <= x_cnt;
            if (y_cnt != 10'h3FF) y_cnt <= y_cnt + 10'd1;
          end
        end
      end
    end
  end

`ifdef VGA_CAPTURE_BBOX_EN
  logic [9:0] min_x, max_x, min_y, max_y;
  logic       hit_acc;
  logic [9:0] res_min_x, res_max_x, res_min_y, res_max_y;
  logic       res_hit;
  logic [9:0] snap_min_x, snap_max_x, snap_min_y, snap_max_y;
  logic       pixel_hit;
  logic       unused_inputs;

  assign pixel_hit = strobe && blank_q && (state == ST_ACTIVE) &&
                     (r_q == KEY_R) && (g_q == KEY_G) && (b_q == KEY_B);
  assign status_hit    = res_hit;
  assign unused_inputs = hs_q;

  // Bounding box of key-colour pixels in the frame being measured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_x   <= 10'd0;
      max_x   <= 10'd0;
      min_y   <= 10'd0;
      max_y   <= 10'd0;
      hit_acc <= 1'b0;
    end else if (start_frame) begin
      min_x   <= 10'd0;
      max_x   <= 10'd0;
      min_y   <= 10'd0;
      max_y   <= 10'd0;
      hit_acc <= 1'b0;
    end else if (pixel_hit) begin
      hit_acc <= 1'b1;
      if (!hit_acc) begin
        min_x <= x_cnt;
        max_x <= x_cnt;
        min_y <= y_cnt;
        max_y <= y_cnt;
      end else begin
        if (x_cnt < min_x) min_x <= x_cnt;
        if (x_cnt > max_x) max_x <= x_cnt;
        if (y_cnt < min_y) min_y <= y_cnt;
        if (y_cnt > max_y) max_y <= y_cnt;
      end
    end
  end

  // Published bounding box and its read snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_min_x  <= 10'd0;
      res_max_x  <= 10'd0;
      res_min_y  <= 10'd0;
      res_max_y  <= 10'd0;
      res_hit    <= 1'b0;
      snap_min_x <= 10'd0;
      snap_max_x <= 10'd0;
      snap_min_y <= 10'd0;
      snap_max_y <= 10'd0;
    end else begin
      if (publish) begin
        res_min_x <= min_x;
        res_max_x <= max_x;
        res_min_y <= min_y;
        res_max_y <= max_y;
        res_hit   <= hit_acc;
      end
      if (rd_status) begin
        snap_min_x <= res_min_x;
        snap_max_x <= res_max_x;
        snap_min_y <= res_min_y;
        snap_max_y <= res_max_y;
      end
    end
  end
`else
  logic unused_inputs;
  assign status_hit    = 1'b0;
  assign unused_inputs = ^{hs_q, r_q, g_q, b_q};
`endif

  // Publish frame geometry and count; status read clears irq/valid unless a publish lands together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_width   <= 10'd0;
      res_height  <= 10'd0;
      frame_count <= 8'd0;
      frame_valid <= 1'b0;
      irq         <= 1'b0;
    end else if (publish) begin
      res_width   <= line_width;
      res_height  <= y_cnt;
      frame_count <= frame_count + 8'd1;
      frame_valid <= 1'b1;
      irq         <= 1'b1;
    end else if (rd_status) begin
      frame_valid <= 1'b0;
      irq         <= 1'b0;
    end
  end

  // Snapshot taken on status read so multi-byte fields stay coherent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_width       <= 10'd0;
      snap_height      <= 10'd0;
      snap_frame_count <= 8'd0;
    end else if (rd_status) begin
      snap_width       <= res_width;
      snap_height      <= res_height;
      snap_frame_count <= frame_count;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 8'd0;
    end else if (rd_en) begin
      case (address)
        4'd0:  readdata <= {5'b0, irq, status_hit, frame_valid};
        4'd1:  readdata <= snap_width[7:0];
        4'd2:  readdata <= {6'b0, snap_width[9:8]};
        4'd3:  readdata <= snap_height[7:0];
        4'd4:  readdata <= {6'b0, snap_height[9:8]};
`ifdef VGA_CAPTURE_BBOX_EN
        4'd5:  readdata <= snap_min_x[7:0];
        4'd6:  readdata <= {6'b0, snap_min_x[9:8]};
        4'd7:  readdata <= snap_max_x[7:0];
        4'd8:  readdata <= {6'b0, snap_max_x[9:8]};
        4'd9:  readdata <= snap_min_y[7:0];
        4'd10: readdata <= {6'b0, snap_min_y[9:8]};
        4'd11: readdata <= snap_max_y[7:0];
        4'd12: readdata <= {6'b0, snap_max_y[9:8]};
`endif
        4'd13: readdata <= snap_frame_count;
        default: readdata <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed bench for vga_capture on a reduced-size raster
module tb_vga_capture;

`ifdef VGA_CAPTURE_BBOX_EN
  localparam bit BB = 1'b1;
`else
  localparam bit BB = 1'b0;
`endif
  localparam logic [23:0] KEY = 24'hFFFFFF;
  localparam logic [23:0] BG  = 24'h000080;
  localparam int HB = 4;

  logic       clk, reset, vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       chipselect, read;
  logic [3:0] address;
  logic [7:0] readdata;
  logic       irq;
  int         checks, errors;
  logic [7:0] st;

  vga_capture dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .chipselect(chipselect), .read(read), .address(address),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rdc(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check(tag, {8'h0, d}, {8'h0, exp});
  endtask

  // One pixel = two clk, low then high phase of vga_clk; optional status read lands on the second edge
  task automatic px(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb, input bit rd0);
    vga_clk = 1'b0; vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = rgb;
    @(posedge clk); #1;
    vga_clk = 1'b1;
    if (rd0) begin chipselect = 1'b1; read = 1'b1; address = 4'd0; end
    @(posedge clk); #1;
    if (rd0) begin chipselect = 1'b0; read = 1'b0; end
  endtask

  task automatic blank_line(input logic vs, input bit rd0);
    for (int p = 0; p < HB + 4; p++)
      px((p >= 2 && p < 4) ? 1'b0 : 1'b1, vs, 1'b0, BG, rd0 && (p == 0));
  endtask

  // Frame: 2 vsync lines, 2 back porch, h active lines of w pixels, 2 front porch
  task automatic gen_frame(input int w, input int h, input int cx, input int cy,
                           input bit rd_vs, input int rst_line);
    int dx, dy;
    blank_line(1'b0, rd_vs);
    blank_line(1'b0, 1'b0);
    blank_line(1'b1, 1'b0);
    blank_line(1'b1, 1'b0);
    for (int y = 0; y < h; y++) begin
      if (y == rst_line) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      for (int p = 0; p < w + HB; p++) begin
        if (p < w) begin
          dx = p - cx; dy = y - cy;
          px(1'b1, 1'b1, 1'b1, (dx * dx + dy * dy <= 9) ? KEY : BG, 1'b0);
        end else begin
          px((p == w + 1 || p == w + 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, BG, 1'b0);
        end
      end
    end
    blank_line(1'b1, 1'b0);
    blank_line(1'b1, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = 8'd0; vga_g = 8'd0; vga_b = 8'd0;
    chipselect = 1'b0; read = 1'b0; address = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", {8'h0, readdata}, 16'h0);
    check("reset_irq", {15'h0, irq}, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Ball at (20,15) r=3 on 32x24; second vsync publishes the first frame
    gen_frame(32, 24, 20, 15, 1'b0, -1);
    gen_frame(32, 24, 20, 15, 1'b0, -1);
    check("a_irq", {15'h0, irq}, 16'h1);
    rdc("a_status", 4'd0, BB ? 8'h07 : 8'h05);
    check("a_irq_cleared", {15'h0, irq}, 16'h0);
    rdc("a_width_l", 4'd1, 8'h20);
    rdc("a_width_h", 4'd2, 8'h00);
    rdc("a_height_l", 4'd3, 8'h18);
    rdc("a_height_h", 4'd4, 8'h00);
    rdc("a_min_x_l", 4'd5, BB ? 8'h11 : 8'h00);
    rdc("a_min_x_h", 4'd6, 8'h00);
    rdc("a_max_x_l", 4'd7, BB ? 8'h17 : 8'h00);
    rdc("a_max_x_h", 4'd8, 8'h00);
    rdc("a_min_y_l", 4'd9, BB ? 8'h0C : 8'h00);
    rdc("a_min_y_h", 4'd10, 8'h00);
    rdc("a_max_y_l", 4'd11, BB ? 8'h12 : 8'h00);
    rdc("a_max_y_h", 4'd12, 8'h00);
    rdc("a_frame_count", 4'd13, 8'h01);
    rdc("a_addr14", 4'd14, 8'h00);
    rdc("a_addr15", 4'd15, 8'h00);

    // Ball moves to (10,8); snapshot must stay until the next status read
    gen_frame(32, 24, 10, 8, 1'b0, -1);
    gen_frame(32, 24, 10, 8, 1'b0, -1);
    rdc("b_old_min_x", 4'd5, BB ? 8'h11 : 8'h00);
    rdc("b_old_width", 4'd1, 8'h20);
    rdc("b_status", 4'd0, BB ? 8'h07 : 8'h05);
    rdc("b_frame_count", 4'd13, 8'h03);
    rdc("b_min_x", 4'd5, BB ? 8'h07 : 8'h00);
    rdc("b_min_y", 4'd9, BB ? 8'h05 : 8'h00);

    // Ball off-screen: no hit, cleared bbox
    gen_frame(32, 24, 1500, 15, 1'b0, -1);
    gen_frame(32, 24, 1500, 15, 1'b0, -1);
    rdc("c_status", 4'd0, 8'h05);
    rdc("c_max_x", 4'd7, 8'h00);
    rdc("c_max_y", 4'd11, 8'h00);
    rdc("c_frame_count", 4'd13, 8'h05);

    // Status read coinciding with publish: old status returned, set wins
    gen_frame(32, 24, 1500, 15, 1'b1, -1);
    check("d_read_at_publish", {8'h0, readdata}, 16'h0000);
    check("d_irq_after", {15'h0, irq}, 16'h1);
    rdc("d_status", 4'd0, 8'h05);

    // Reset mid-frame: publish only after a full vs low-high-low sequence
    gen_frame(32, 24, 20, 15, 1'b0, 10);
    check("e_irq_after_reset", {15'h0, irq}, 16'h0);
    check("e_readdata_after_reset", {8'h0, readdata}, 16'h0);
    gen_frame(32, 24, 20, 15, 1'b0, -1);
    check("e_irq_first_vs", {15'h0, irq}, 16'h0);
    rdc("e_status_zero", 4'd0, 8'h00);
    rdc("e_width_zero", 4'd1, 8'h00);
    rdc("e_count_zero", 4'd13, 8'h00);
    gen_frame(32, 24, 20, 15, 1'b0, -1);
    check("e_irq_second_vs", {15'h0, irq}, 16'h1);
    rd(4'd0, st);
    check("e_status", {8'h0, st}, {8'h0, BB ? 8'h07 : 8'h05});
    rdc("e_frame_count", 4'd13, 8'h01);
    rdc("e_min_x", 4'd5, BB ? 8'h11 : 8'h00);

    // Over-long lines saturate the width at 1023
    gen_frame(1030, 2, 1500, 15, 1'b0, -1);
    gen_frame(32, 24, 20, 15, 1'b0, -1);
    rdc("f_status", 4'd0, 8'h05);
    rdc("f_width_l", 4'd1, 8'hFF);
    rdc("f_width_h", 4'd2, 8'h03);
    rdc("f_height_l", 4'd3, 8'h02);
    rdc("f_frame_count", 4'd13, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
